// File: rtl/pod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pod_pkg
// Description : Shared pod definitions: bring-up state encoding and default
//               timing constants (also used by the power controller's mate
//               delay).
// Revision    : 1.0 - initial release
// ============================================================================
package pod_pkg;

  // Default timings at 125 MHz
  localparam int unsigned c_pod_settle_cycles  = 32'd1250000;   // 10 ms
  localparam int unsigned c_pod_pgood_timeout  = 32'd12500000;  // 100 ms
  localparam int unsigned c_pod_reset_hold     = 32'd125000;    // 1 ms
  localparam int          c_pod_cnt_width      = 24;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETTLE     = 3'd1,
    S_WAIT_PGOOD = 3'd2,
    S_RESET_HOLD = 3'd3,
    S_READY      = 3'd4,
    S_FAULT      = 3'd5
  } pod_bringup_state_t;

endpackage
`default_nettype wire

// File: rtl/pod_bringup_sequencer_sync.sv
`default_nettype none
// ============================================================================
// Module      : ThreeStageSynchronizer
// Description : Three-flop synchronizer for a single asynchronous bit, with
//               an optional input register ahead of the chain.
// Revision    : 1.0 - initial release
// ============================================================================
module ThreeStageSynchronizer #(
  parameter bit INIT   = 1'b0,
  parameter bit IN_REG = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic       w_d_in;
  logic [2:0] r_sync;

  generate
    if (IN_REG) begin : g_in_reg
      logic r_in;
      // Optional register on the raw input before the synchronizing chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_in <= INIT;
        else        r_in <= d;
      end
      assign w_d_in = r_in;
    end else begin : g_no_in_reg
      assign w_d_in = d;
    end
  endgenerate

  // Shift the input through three flops to resolve metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {3{INIT}};
    else        r_sync <= {r_sync[1:0], w_d_in};
  end

  assign q = r_sync[2];

endmodule
`default_nettype wire

// File: rtl/pod_bringup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pod_bringup_sequencer
// Description : After pod power is enabled, waits for the rail to settle,
//               checks power-good with a timeout, enables the I/O buffers,
//               holds then releases pod reset and flags the pod ready.
//               Power-good faults are sticky; bring-ups are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module pod_bringup_sequencer
  import pod_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = c_pod_settle_cycles,
  parameter int unsigned PGOOD_TIMEOUT = c_pod_pgood_timeout,
  parameter int unsigned RESET_HOLD    = c_pod_reset_hold,
  parameter int          CNT_WIDTH     = c_pod_cnt_width
) (
  input  logic        clk_125mhz,
  input  logic        rst_n,
  input  logic        pod_power_en,
  input  logic        pod_power_good,
  input  logic        clear_fault,
  output logic        pod_rst_n,
  output logic        pod_io_en,
  output logic        pod_ready,
  output logic        pgood_fault,
  output logic [15:0] bringup_count
);

  localparam logic [CNT_WIDTH-1:0] c_settle_last  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_timeout_last = CNT_WIDTH'(PGOOD_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] c_hold_last    = CNT_WIDTH'(RESET_HOLD - 1);

  pod_bringup_state_t r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic        r_pod_rst_n,  w_pod_rst_n_nxt;
  logic        r_pod_io_en,  w_pod_io_en_nxt;
  logic        r_pod_ready,  w_pod_ready_nxt;
  logic        r_pgood_fault, w_pgood_fault_nxt;
  logic [15:0] r_bringup_count, w_bringup_count_nxt;
  logic        w_pgood_sync;

  ThreeStageSynchronizer #(
    .INIT   (1'b0),
    .IN_REG (1'b0)
  ) u_pgood_sync (
    .clk   (clk_125mhz),
    .rst_n (rst_n),
    .d     (pod_power_good),
    .q     (w_pgood_sync)
  );

  // State, counter and all outputs are registered together
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_pod_rst_n     <= 1'b0;
      r_pod_io_en     <= 1'b0;
      r_pod_ready     <= 1'b0;
      r_pgood_fault   <= 1'b0;
      r_bringup_count <= 16'h0000;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_pod_rst_n     <= w_pod_rst_n_nxt;
      r_pod_io_en     <= w_pod_io_en_nxt;
      r_pod_ready     <= w_pod_ready_nxt;
      r_pgood_fault   <= w_pgood_fault_nxt;
      r_bringup_count <= w_bringup_count_nxt;
    end
  end

  // Next-state and next-output decode; a fault set later in this block
  // overrides the clear applied in the defaults
  always_comb begin
    w_state_nxt         = r_state;
    w_cnt_nxt           = r_cnt;
    w_pod_rst_n_nxt     = r_pod_rst_n;
    w_pod_io_en_nxt     = r_pod_io_en;
    w_pod_ready_nxt     = r_pod_ready;
    w_pgood_fault_nxt   = clear_fault ? 1'b0 : r_pgood_fault;
    w_bringup_count_nxt = r_bringup_count;

    if ((r_state != S_IDLE) && !pod_power_en) begin
      // Unplug is a normal event: drop everything, no fault
      w_state_nxt     = S_IDLE;
      w_cnt_nxt       = '0;
      w_pod_rst_n_nxt = 1'b0;
      w_pod_io_en_nxt = 1'b0;
      w_pod_ready_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_pod_rst_n_nxt = 1'b0;
          w_pod_io_en_nxt = 1'b0;
          w_pod_ready_nxt = 1'b0;
          if (pod_power_en) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == c_settle_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_PGOOD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_WAIT_PGOOD: begin
          if (w_pgood_sync) begin
            w_pod_io_en_nxt = 1'b1;
            w_cnt_nxt       = '0;
            w_state_nxt     = S_RESET_HOLD;
          end else if (r_cnt == c_timeout_last) begin
            w_pgood_fault_nxt = 1'b1;
            w_cnt_nxt         = '0;
            w_state_nxt       = S_FAULT;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RESET_HOLD: begin
          if (!w_pgood_sync) begin
            w_pgood_fault_nxt = 1'b1;
            w_pod_io_en_nxt   = 1'b0;
            w_cnt_nxt         = '0;
            w_state_nxt       = S_FAULT;
          end else if (r_cnt == c_hold_last) begin
            w_pod_rst_n_nxt = 1'b1;
            w_pod_ready_nxt = 1'b1;
            w_cnt_nxt       = '0;
            if (r_bringup_count != 16'hffff)
              w_bringup_count_nxt = r_bringup_count + 16'h0001;
            w_state_nxt = S_READY;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_READY: begin
          if (!w_pgood_sync) begin
            w_pod_rst_n_nxt   = 1'b0;
            w_pod_io_en_nxt   = 1'b0;
            w_pod_ready_nxt   = 1'b0;
            w_pgood_fault_nxt = 1'b1;
            w_state_nxt       = S_FAULT;
          end
        end
        S_FAULT: begin
          w_pod_rst_n_nxt = 1'b0;
          w_pod_io_en_nxt = 1'b0;
          w_pod_ready_nxt = 1'b0;
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_cnt_nxt       = '0;
          w_pod_rst_n_nxt = 1'b0;
          w_pod_io_en_nxt = 1'b0;
          w_pod_ready_nxt = 1'b0;
        end
      endcase
    end
  end

  assign pod_rst_n     = r_pod_rst_n;
  assign pod_io_en     = r_pod_io_en;
  assign pod_ready     = r_pod_ready;
  assign pgood_fault   = r_pgood_fault;
  assign bringup_count = r_bringup_count;

endmodule
`default_nettype wire

// File: tb/tb_pod_bringup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pod_bringup_sequencer
// Description : Directed self-checking bench for pod_bringup_sequencer with
//               short timings (settle 8, timeout 16, reset hold 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pod_bringup_sequencer;

  localparam int unsigned SETTLE  = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned HOLD    = 4;

  // Edge numbering: edge 1 is the first rising edge that sees power_en=1.
  // Edge 1 enters SETTLE, edges 2..9 count, edge 9+n leaves WAIT_PGOOD.
  localparam int c_io_edge      = SETTLE + 2;              // n = 1
  localparam int c_ready_edge   = SETTLE + 1 + HOLD + 1;   // 14
  localparam int c_timeout_edge = 1 + SETTLE + TIMEOUT;    // 25

  logic        clk_125mhz = 1'b0;
  logic        rst_n;
  logic        pod_power_en;
  logic        pod_power_good;
  logic        clear_fault;
  logic        pod_rst_n;
  logic        pod_io_en;
  logic        pod_ready;
  logic        pgood_fault;
  logic [15:0] bringup_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #4 clk_125mhz = ~clk_125mhz;

  pod_bringup_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .PGOOD_TIMEOUT (TIMEOUT),
    .RESET_HOLD    (HOLD),
    .CNT_WIDTH     (24)
  ) dut (
    .clk_125mhz     (clk_125mhz),
    .rst_n          (rst_n),
    .pod_power_en   (pod_power_en),
    .pod_power_good (pod_power_good),
    .clear_fault    (clear_fault),
    .pod_rst_n      (pod_rst_n),
    .pod_io_en      (pod_io_en),
    .pod_ready      (pod_ready),
    .pgood_fault    (pgood_fault),
    .bringup_count  (bringup_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_125mhz);
  endtask

  // Raise power_en from IDLE and record the edges at which io_en and ready rise
  task automatic bringup(output int io_edge, output int rdy_edge);
    io_edge  = -1;
    rdy_edge = -1;
    pod_power_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_125mhz);
      if (io_edge < 0 && pod_io_en) io_edge = k;
      if (pod_ready) begin
        rdy_edge = k;
        break;
      end
    end
  endtask

  // Raise power_en with pgood low and record the edge the timeout fault appears
  task automatic timeout_run(output int f_edge);
    f_edge = -1;
    pod_power_en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_125mhz);
      if (pgood_fault) begin
        f_edge = k;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
  endtask

  initial begin
    int io_e, rdy_e, f_e;
    rst_n          = 1'b0;
    pod_power_en   = 1'b0;
    pod_power_good = 1'b1;
    clear_fault    = 1'b0;
    tick(3);

    // Reset state
    check("rst_pod_rst_n", 32'(pod_rst_n), 32'd0);
    check("rst_io_en",     32'(pod_io_en), 32'd0);
    check("rst_ready",     32'(pod_ready), 32'd0);
    check("rst_fault",     32'(pgood_fault), 32'd0);
    check("rst_count",     32'(bringup_count), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Bring-up with pgood already good
    bringup(io_e, rdy_e);
    check("t1_io_edge",    32'(io_e), 32'(c_io_edge));
    check("t1_ready_edge", 32'(rdy_e), 32'(c_ready_edge));
    check("t1_pod_rst_n",  32'(pod_rst_n), 32'd1);
    check("t1_io_en",      32'(pod_io_en), 32'd1);
    check("t1_count",      32'(bringup_count), 32'd1);

    // pgood lost in READY: three sync edges, then the FSM reacts
    pod_power_good = 1'b0;
    tick(3);
    check("t3_ready_before", 32'(pod_ready), 32'd1);
    tick(1);
    check("t3_ready_off",  32'(pod_ready), 32'd0);
    check("t3_io_off",     32'(pod_io_en), 32'd0);
    check("t3_rst_off",    32'(pod_rst_n), 32'd0);
    check("t3_fault",      32'(pgood_fault), 32'd1);
    pod_power_en = 1'b0;
    tick(1);
    pulse_clear();
    check("t3_fault_clr",  32'(pgood_fault), 32'd0);
    pod_power_good = 1'b1;
    tick(4);
    bringup(io_e, rdy_e);
    check("t3_ready_edge", 32'(rdy_e), 32'(c_ready_edge));
    check("t3_count",      32'(bringup_count), 32'd2);

    // Power-good never arrives: timeout fault
    pod_power_en = 1'b0;
    tick(2);
    pod_power_good = 1'b0;
    tick(4);
    timeout_run(f_e);
    check("t2_fault_edge", 32'(f_e), 32'(c_timeout_edge));
    check("t2_io_en",      32'(pod_io_en), 32'd0);
    check("t2_ready",      32'(pod_ready), 32'd0);
    pod_power_en = 1'b0;
    tick(1);
    check("t2_fault_idle", 32'(pgood_fault), 32'd1);
    pulse_clear();
    check("t2_fault_clr",  32'(pgood_fault), 32'd0);

    // clear_fault coinciding with the timeout: set wins
    pod_power_en = 1'b1;
    tick(c_timeout_edge - 1);
    check("t5_no_fault_yet", 32'(pgood_fault), 32'd0);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    check("t5_set_wins",   32'(pgood_fault), 32'd1);
    tick(2);
    check("t5_sticky",     32'(pgood_fault), 32'd1);
    pulse_clear();
    check("t5_clear",      32'(pgood_fault), 32'd0);
    check("t5_io_off",     32'(pod_io_en), 32'd0);
    pod_power_en = 1'b0;
    tick(2);

    // Unplug during SETTLE
    pod_power_good = 1'b1;
    tick(4);
    pod_power_en = 1'b1;
    tick(4);
    pod_power_en = 1'b0;
    tick(12);
    check("t4s_io_en",     32'(pod_io_en), 32'd0);
    check("t4s_fault",     32'(pgood_fault), 32'd0);

    // Unplug during WAIT_PGOOD (pgood held low to stay there)
    pod_power_good = 1'b0;
    tick(4);
    pod_power_en = 1'b1;
    tick(12);
    pod_power_en = 1'b0;
    tick(1);
    check("t4w_io_en",     32'(pod_io_en), 32'd0);
    tick(20);
    check("t4w_fault",     32'(pgood_fault), 32'd0);

    // Unplug during RESET_HOLD
    pod_power_good = 1'b1;
    tick(4);
    pod_power_en = 1'b1;
    tick(c_io_edge + 1);
    check("t4r_io_on",     32'(pod_io_en), 32'd1);
    pod_power_en = 1'b0;
    tick(1);
    check("t4r_io_off",    32'(pod_io_en), 32'd0);
    check("t4r_ready",     32'(pod_ready), 32'd0);
    check("t4r_fault",     32'(pgood_fault), 32'd0);
    check("t4r_count",     32'(bringup_count), 32'd2);

    // Third bring-up, then async reset mid-RESET_HOLD
    tick(1);
    bringup(io_e, rdy_e);
    check("t6_count3",     32'(bringup_count), 32'd3);
    pod_power_en = 1'b0;
    tick(1);
    pod_power_en = 1'b1;
    tick(c_io_edge + 1);
    check("t6_io_on",      32'(pod_io_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_io",    32'(pod_io_en), 32'd0);
    check("t6_async_count", 32'(bringup_count), 32'd0);
    check("t6_async_rst_n", 32'(pod_rst_n), 32'd0);
    pod_power_en = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);

    // Saturation of the bring-up counter
    force dut.r_bringup_count = 16'hfffe;
    tick(1);
    release dut.r_bringup_count;
    tick(1);
    check("t6_forced",     32'(bringup_count), 32'h0000fffe);
    for (int i = 0; i < 3; i++) begin
      bringup(io_e, rdy_e);
      check("t6_sat_count", 32'(bringup_count), 32'h0000ffff);
      pod_power_en = 1'b0;
      tick(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
